// File: rtl/mem_xfer_arbiter.sv
// Arbitrates the memory-transfer start interface between the AHB and CSR requesters.
// Issues one transfer at a time, tracks the cs_n window and enforces a cs_n-high gap.
module mem_xfer_arbiter #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int TO_CYCLES      = 255
) (
  input  logic                      mem_clk,
  input  logic                      reset_n,
  input  logic                      ahb_req,
  input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr,
  input  logic                      ahb_wr_rd,
  input  logic [7:0]                ahb_len,
  input  logic                      csr_req,
  input  logic                      csr_prio,
  input  logic [4:0]                cs_high,
  input  logic                      cs_n,
  input  logic                      ahb_start_mem_xfer_ack,
  input  logic                      csr_start_mem_xfer_ack,
  output logic                      ahb_start_mem_xfer,
  output logic                      csr_start_mem_xfer,
  output logic [AHB_ADDR_WIDTH-1:0] addr_mem_xfer,
  output logic                      xfer_wr_rd,
  output logic [7:0]                xfer_ahb_len,
  output logic                      ahb_gnt,
  output logic                      csr_gnt,
  output logic [1:0]                arb_owner,
  output logic                      arb_busy,
  output logic                      xfer_timeout,
  output logic [2:0]                dbg_state
);

  // Handshake: a req is a level held until its gnt pulse; a start is a level held
  // until its own ack is sampled high; acks for the other requester are ignored.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_CS = 3'd2,
    S_ACTIVE  = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_AHB  = 2'b01;
  localparam logic [1:0] OWN_CSR  = 2'b10;
  localparam logic [7:0] TO_LIMIT = 8'(TO_CYCLES);

  state_t                    r_state, w_state_nxt;
  logic                      r_ahb_start, w_ahb_start_nxt;
  logic                      r_csr_start, w_csr_start_nxt;
  logic [AHB_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic                      r_wr_rd, w_wr_rd_nxt;
  logic [7:0]                r_len, w_len_nxt;
  logic                      r_ahb_gnt, w_ahb_gnt_nxt;
  logic                      r_csr_gnt, w_csr_gnt_nxt;
  logic [1:0]                r_owner, w_owner_nxt;
  logic                      r_busy, w_busy_nxt;
  logic                      r_timeout, w_timeout_nxt;
  logic [7:0]                r_wdog, w_wdog_nxt;
  logic [4:0]                r_gap, w_gap_nxt;
  logic                      r_last_csr, w_last_csr_nxt;
  logic                      w_csr_wins;
  logic                      w_ack_match;

  // Last owner resets to CSR so that AHB takes the first round-robin tie.
  assign w_csr_wins  = csr_req && (csr_prio || !ahb_req || !r_last_csr);
  assign w_ack_match = ((r_owner == OWN_AHB) && ahb_start_mem_xfer_ack) ||
                       ((r_owner == OWN_CSR) && csr_start_mem_xfer_ack);

  always_ff @(posedge mem_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ahb_start <= 1'b0;
      r_csr_start <= 1'b0;
      r_addr      <= '0;
      r_wr_rd     <= 1'b0;
      r_len       <= 8'd0;
      r_ahb_gnt   <= 1'b0;
      r_csr_gnt   <= 1'b0;
      r_owner     <= OWN_NONE;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_wdog      <= 8'd0;
      r_gap       <= 5'd0;
      r_last_csr  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_ahb_start <= w_ahb_start_nxt;
      r_csr_start <= w_csr_start_nxt;
      r_addr      <= w_addr_nxt;
      r_wr_rd     <= w_wr_rd_nxt;
      r_len       <= w_len_nxt;
      r_ahb_gnt   <= w_ahb_gnt_nxt;
      r_csr_gnt   <= w_csr_gnt_nxt;
      r_owner     <= w_owner_nxt;
      r_busy      <= w_busy_nxt;
      r_timeout   <= w_timeout_nxt;
      r_wdog      <= w_wdog_nxt;
      r_gap       <= w_gap_nxt;
      r_last_csr  <= w_last_csr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (ahb_req || csr_req) w_state_nxt = S_ISSUE;
      S_ISSUE:   if (w_ack_match) w_state_nxt = S_WAIT_CS;
      S_WAIT_CS: begin
        if (!cs_n)                     w_state_nxt = S_ACTIVE;
        else if (r_wdog == TO_LIMIT)   w_state_nxt = S_GAP;
      end
      S_ACTIVE:  if (cs_n) w_state_nxt = S_GAP;
      S_GAP:     if (r_gap == 5'd0) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead and registered.
  always_comb begin
    w_ahb_start_nxt = 1'b0;
    w_csr_start_nxt = 1'b0;
    w_addr_nxt      = r_addr;
    w_wr_rd_nxt     = r_wr_rd;
    w_len_nxt       = r_len;
    w_ahb_gnt_nxt   = 1'b0;
    w_csr_gnt_nxt   = 1'b0;
    w_owner_nxt     = r_owner;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_timeout_nxt   = 1'b0;
    w_wdog_nxt      = r_wdog;
    w_gap_nxt       = r_gap;
    w_last_csr_nxt  = r_last_csr;
    case (r_state)
      S_IDLE: begin
        if (ahb_req || csr_req) begin
          if (w_csr_wins) begin
            w_owner_nxt     = OWN_CSR;
            w_csr_start_nxt = 1'b1;
          end else begin
            w_owner_nxt     = OWN_AHB;
            w_ahb_start_nxt = 1'b1;
            w_addr_nxt      = ahb_addr;
            w_wr_rd_nxt     = ahb_wr_rd;
            w_len_nxt       = ahb_len;
          end
        end
      end
      S_ISSUE: begin
        if (w_ack_match) begin
          w_ahb_gnt_nxt = (r_owner == OWN_AHB);
          w_csr_gnt_nxt = (r_owner == OWN_CSR);
          w_wdog_nxt    = 8'd0;
        end else begin
          w_ahb_start_nxt = (r_owner == OWN_AHB);
          w_csr_start_nxt = (r_owner == OWN_CSR);
        end
      end
      S_WAIT_CS: begin
        if (cs_n) begin
          if (r_wdog == TO_LIMIT) begin
            w_timeout_nxt = 1'b1;
            w_gap_nxt     = cs_high;
          end else begin
            w_wdog_nxt = r_wdog + 8'd1;
          end
        end
      end
      S_ACTIVE: if (cs_n) w_gap_nxt = cs_high;
      S_GAP: begin
        if (r_gap == 5'd0) begin
          w_owner_nxt    = OWN_NONE;
          w_last_csr_nxt = (r_owner == OWN_CSR);
        end else begin
          w_gap_nxt = r_gap - 5'd1;
        end
      end
      default: ;
    endcase
  end

  assign ahb_start_mem_xfer = r_ahb_start;
  assign csr_start_mem_xfer = r_csr_start;
  assign addr_mem_xfer      = r_addr;
  assign xfer_wr_rd         = r_wr_rd;
  assign xfer_ahb_len       = r_len;
  assign ahb_gnt            = r_ahb_gnt;
  assign csr_gnt            = r_csr_gnt;
  assign arb_owner          = r_owner;
  assign arb_busy           = r_busy;
  assign xfer_timeout       = r_timeout;
  assign dbg_state          = r_state;

endmodule

// File: tb/tb_mem_xfer_arbiter.sv
// Directed bench for mem_xfer_arbiter: single AHB read, round-robin tie, strict CSR
// priority, watchdog expiry, async reset mid-transfer and a crossed ack.
module tb_mem_xfer_arbiter;

  localparam int AW = 32;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_WAIT_CS = 3'd2;
  localparam logic [2:0] ST_ACTIVE  = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;
  localparam logic [1:0] OWN_NONE   = 2'b00;
  localparam logic [1:0] OWN_AHB    = 2'b01;
  localparam logic [1:0] OWN_CSR    = 2'b10;

  logic          mem_clk;
  logic          reset_n;
  logic          ahb_req;
  logic [AW-1:0] ahb_addr;
  logic          ahb_wr_rd;
  logic [7:0]    ahb_len;
  logic          csr_req;
  logic          csr_prio;
  logic [4:0]    cs_high;
  logic          cs_n;
  logic          ahb_ack;
  logic          csr_ack;
  logic          ahb_start_mem_xfer;
  logic          csr_start_mem_xfer;
  logic [AW-1:0] addr_mem_xfer;
  logic          xfer_wr_rd;
  logic [7:0]    xfer_ahb_len;
  logic          ahb_gnt;
  logic          csr_gnt;
  logic [1:0]    arb_owner;
  logic          arb_busy;
  logic          xfer_timeout;
  logic [2:0]    dbg_state;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  mem_xfer_arbiter #(.AHB_ADDR_WIDTH(AW), .TO_CYCLES(255)) dut (
    .mem_clk               (mem_clk),
    .reset_n               (reset_n),
    .ahb_req               (ahb_req),
    .ahb_addr              (ahb_addr),
    .ahb_wr_rd             (ahb_wr_rd),
    .ahb_len               (ahb_len),
    .csr_req               (csr_req),
    .csr_prio              (csr_prio),
    .cs_high               (cs_high),
    .cs_n                  (cs_n),
    .ahb_start_mem_xfer_ack(ahb_ack),
    .csr_start_mem_xfer_ack(csr_ack),
    .ahb_start_mem_xfer    (ahb_start_mem_xfer),
    .csr_start_mem_xfer    (csr_start_mem_xfer),
    .addr_mem_xfer         (addr_mem_xfer),
    .xfer_wr_rd            (xfer_wr_rd),
    .xfer_ahb_len          (xfer_ahb_len),
    .ahb_gnt               (ahb_gnt),
    .csr_gnt               (csr_gnt),
    .arb_owner             (arb_owner),
    .arb_busy              (arb_busy),
    .xfer_timeout          (xfer_timeout),
    .dbg_state             (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({ahb_start_mem_xfer, csr_start_mem_xfer, addr_mem_xfer, xfer_wr_rd,
                xfer_ahb_len, ahb_gnt, csr_gnt, arb_owner, arb_busy, xfer_timeout});
  endfunction

  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    ahb_ack = 1'b0;
    csr_ack = 1'b0;
    cs_n    = 1'b1;
    repeat (2) tick();
    check({tag, "_outs_zero"}, all_outs(), 64'd0);
    check({tag, "_state_idle"}, 64'(dbg_state), 64'(ST_IDLE));
    reset_n = 1'b1;
  endtask

  // One full transfer; the expected owner comes from the scoreboard queue.
  task automatic run_xfer(input string tag, input int cs_cycles, input bit drop_ahb,
                          input bit drop_csr);
    int         n;
    logic [1:0] exp_own;
    exp_own = exp_q.pop_front();
    n = 0;
    while (!(ahb_start_mem_xfer || csr_start_mem_xfer) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_owner"}, 64'(arb_owner), 64'(exp_own));
    check({tag, "_ahb_start"}, 64'(ahb_start_mem_xfer), 64'(exp_own == OWN_AHB));
    check({tag, "_csr_start"}, 64'(csr_start_mem_xfer), 64'(exp_own == OWN_CSR));
    if (exp_own == OWN_AHB) ahb_ack = 1'b1;
    else                    csr_ack = 1'b1;
    tick();
    ahb_ack = 1'b0;
    csr_ack = 1'b0;
    check({tag, "_ahb_gnt"}, 64'(ahb_gnt), 64'(exp_own == OWN_AHB));
    check({tag, "_csr_gnt"}, 64'(csr_gnt), 64'(exp_own == OWN_CSR));
    if (drop_ahb) ahb_req = 1'b0;
    if (drop_csr) csr_req = 1'b0;
    cs_n = 1'b0;
    repeat (cs_cycles) tick();
    cs_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (arb_busy && n < 60);
    check({tag, "_done_busy"}, 64'(arb_busy), 64'd0);
    check({tag, "_done_owner"}, 64'(arb_owner), 64'(OWN_NONE));
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    int n;
    reset_n   = 1'b0;
    ahb_req   = 1'b0;
    ahb_addr  = '0;
    ahb_wr_rd = 1'b0;
    ahb_len   = 8'd0;
    csr_req   = 1'b0;
    csr_prio  = 1'b0;
    cs_high   = 5'd4;
    cs_n      = 1'b1;
    ahb_ack   = 1'b0;
    csr_ack   = 1'b0;

    // AHB read alone
    apply_reset("t1_reset");
    tick();
    check("t1_idle_busy", 64'(arb_busy), 64'd0);
    ahb_addr  = 32'h1000_0040;
    ahb_len   = 8'd7;
    ahb_wr_rd = 1'b0;
    ahb_req   = 1'b1;
    tick();
    check("t1_start_c1", 64'(ahb_start_mem_xfer), 64'd1);
    check("t1_csr_start", 64'(csr_start_mem_xfer), 64'd0);
    check("t1_owner", 64'(arb_owner), 64'(OWN_AHB));
    check("t1_busy", 64'(arb_busy), 64'd1);
    check("t1_addr", 64'(addr_mem_xfer), 64'h1000_0040);
    check("t1_len", 64'(xfer_ahb_len), 64'd7);
    check("t1_wr_rd", 64'(xfer_wr_rd), 64'd0);
    tick();
    check("t1_start_c2", 64'(ahb_start_mem_xfer), 64'd1);
    tick();
    check("t1_start_c3", 64'(ahb_start_mem_xfer), 64'd1);
    ahb_ack = 1'b1;
    tick();
    ahb_ack = 1'b0;
    ahb_req = 1'b0;
    check("t1_start_low", 64'(ahb_start_mem_xfer), 64'd0);
    check("t1_gnt", 64'(ahb_gnt), 64'd1);
    check("t1_wait_cs", 64'(dbg_state), 64'(ST_WAIT_CS));
    tick();
    check("t1_gnt_pulse", 64'(ahb_gnt), 64'd0);
    cs_n = 1'b0;
    tick();
    check("t1_active", 64'(dbg_state), 64'(ST_ACTIVE));
    repeat (19) tick();
    cs_n = 1'b1;
    tick();
    n = 0;
    while (dbg_state == ST_GAP && n < 50) begin
      n++;
      tick();
    end
    check("t1_gap_len", 64'(n), 64'd5);
    check("t1_idle_busy_end", 64'(arb_busy), 64'd0);
    check("t1_owner_end", 64'(arb_owner), 64'(OWN_NONE));
    check("t1_addr_hold", 64'(addr_mem_xfer), 64'h1000_0040);

    // Cross-ack: a CSR ack while the AHB start is pending is ignored
    cs_high = 5'd1;
    ahb_addr = 32'h0000_0100;
    ahb_req  = 1'b1;
    tick();
    check("t6_start", 64'(ahb_start_mem_xfer), 64'd1);
    csr_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t6_no_gnt", 64'({ahb_gnt, csr_gnt}), 64'd0);
      check("t6_start_held", 64'(ahb_start_mem_xfer), 64'd1);
      check("t6_issue", 64'(dbg_state), 64'(ST_ISSUE));
    end
    csr_ack = 1'b0;
    exp_q.push_back(OWN_AHB);
    run_xfer("t6_xfer", 3, 1'b1, 1'b0);

    // Watchdog: cs_n never falls after ack
    cs_high = 5'd2;
    ahb_req = 1'b1;
    tick();
    check("t4_start", 64'(ahb_start_mem_xfer), 64'd1);
    ahb_ack = 1'b1;
    tick();
    ahb_ack = 1'b0;
    ahb_req = 1'b0;
    check("t4_gnt", 64'(ahb_gnt), 64'd1);
    n = 0;
    while (!xfer_timeout && n < 400) begin
      tick();
      n++;
    end
    check("t4_timeout_delay", 64'(n), 64'd256);
    check("t4_gap_on_timeout", 64'(dbg_state), 64'(ST_GAP));
    tick();
    check("t4_timeout_pulse", 64'(xfer_timeout), 64'd0);
    check("t4_gap_1", 64'(dbg_state), 64'(ST_GAP));
    tick();
    check("t4_gap_2", 64'(dbg_state), 64'(ST_GAP));
    tick();
    check("t4_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("t4_busy_end", 64'(arb_busy), 64'd0);

    // Round-robin tie from reset: AHB, CSR, AHB
    csr_prio  = 1'b0;
    cs_high   = 5'd1;
    ahb_addr  = 32'hA000_0010;
    ahb_len   = 8'd3;
    ahb_wr_rd = 1'b1;
    ahb_req   = 1'b1;
    csr_req   = 1'b1;
    apply_reset("t2_reset");
    exp_q.push_back(OWN_AHB);
    exp_q.push_back(OWN_CSR);
    exp_q.push_back(OWN_AHB);
    run_xfer("t2_a", 2, 1'b0, 1'b0);
    ahb_addr = 32'hB000_0020;
    ahb_len  = 8'd9;
    run_xfer("t2_b", 2, 1'b0, 1'b0);
    check("t2_addr_kept", 64'(addr_mem_xfer), 64'hA000_0010);
    check("t2_len_kept", 64'(xfer_ahb_len), 64'd3);
    run_xfer("t2_c", 2, 1'b1, 1'b1);
    check("t2_addr_new", 64'(addr_mem_xfer), 64'hB000_0020);
    check("t2_len_new", 64'(xfer_ahb_len), 64'd9);
    check("t2_wr_rd", 64'(xfer_wr_rd), 64'd1);

    // Strict CSR priority from reset: CSR, CSR, then AHB once csr_req drops
    csr_prio = 1'b1;
    ahb_req  = 1'b1;
    csr_req  = 1'b1;
    apply_reset("t3_reset");
    exp_q.push_back(OWN_CSR);
    exp_q.push_back(OWN_CSR);
    exp_q.push_back(OWN_AHB);
    run_xfer("t3_a", 2, 1'b0, 1'b0);
    run_xfer("t3_b", 2, 1'b0, 1'b1);
    run_xfer("t3_c", 2, 1'b1, 1'b0);
    csr_prio = 1'b0;

    // Async reset while in ACTIVE, request held through reset
    cs_high  = 5'd3;
    ahb_addr = 32'h0000_3000;
    ahb_req  = 1'b1;
    tick();
    ahb_ack = 1'b1;
    tick();
    ahb_ack = 1'b0;
    cs_n = 1'b0;
    repeat (2) tick();
    check("t5_active", 64'(dbg_state), 64'(ST_ACTIVE));
    check("t5_owner", 64'(arb_owner), 64'(OWN_AHB));
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_clear", all_outs(), 64'd0);
    check("t5_async_state", 64'(dbg_state), 64'(ST_IDLE));
    cs_n = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    check("t5_restart", 64'(ahb_start_mem_xfer), 64'd1);
    check("t5_restart_owner", 64'(arb_owner), 64'(OWN_AHB));
    exp_q.push_back(OWN_AHB);
    run_xfer("t5_xfer", 2, 1'b1, 1'b0);

    // ---------------- report ----------------
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
